// File: rtl/mux_1_9_win_sel.sv
`default_nettype none
// ============================================================================
// mux_1_9_win_sel : 3x3 raster window with a 1-of-9 register selector.
// Option macro MUX19_OUT_REG_EN adds an output pipeline stage (latency 2).
// Revision 1.0 - initial release
// ============================================================================
module mux_1_9_win_sel #(
   parameter int DATA_W = 8,
   parameter int LINE_W = 64
) (
   input  logic              SYS_CLK,
   input  logic              SYS_RST,
   input  logic              FRAME_SOF,
   input  logic              PIX_VLD,
   input  logic [DATA_W-1:0] PIX_IN,
   input  logic [3:0]        CTRL_REGNUM_SEL,
   output logic [DATA_W-1:0] PIX_OUT,
   output logic              PIX_OUT_VLD,
   output logic              WIN_RDY,
   output logic              SEL_ERR
);

   localparam int            CW       = (LINE_W > 1) ? $clog2(LINE_W) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [CW-1:0]     col;
   logic [CW-1:0]     col_nxt;
   logic [1:0]        row;
   logic [1:0]        row_nxt;
   logic              sof_acc;
   logic              accept;
   logic              rdy_nxt;
   logic [DATA_W-1:0] win     [9];
   logic [DATA_W-1:0] win_nxt [9];
   logic [DATA_W-1:0] lb1     [LINE_W];
   logic [DATA_W-1:0] lb2     [LINE_W];
   logic [DATA_W-1:0] line1;
   logic [DATA_W-1:0] line2;
   logic [DATA_W-1:0] sel_pix;
   logic              sel_bad;
   logic [DATA_W-1:0] s1_pix;
   logic              s1_vld;
   logic              s1_err;

   assign sof_acc = PIX_VLD & FRAME_SOF;
   assign accept  = PIX_VLD & (FRAME_SOF | (state != IDLE));

   // Counters describe the position of the most recently accepted pixel.
   always_comb begin
      col_nxt = col;
      row_nxt = row;
      if (sof_acc) begin
         col_nxt = '0;
         row_nxt = '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col_nxt = '0;
            if (row != 2'd2) begin
               row_nxt = row + 2'd1;
            end
         end else begin
            col_nxt = col + 1'b1;
         end
      end
   end

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         col <= '0;
         row <= '0;
      end else begin
         col <= col_nxt;
         row <= row_nxt;
      end
   end

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (sof_acc) state_nxt = FILL;
         end
         FILL: begin
            if (sof_acc) begin
               state_nxt = FILL;
            end else if (PIX_VLD && (row_nxt == 2'd2) && (col_nxt >= COL_TWO)) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (sof_acc) state_nxt = FILL;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Columns 0 and 1 of every line hold a window straddling the wrap.
   always_comb begin
      WIN_RDY = (state == RUN) && (col >= COL_TWO);
      rdy_nxt = (state_nxt == RUN) && (col_nxt >= COL_TWO);
   end

   assign line1 = lb1[col_nxt];
   assign line2 = lb2[col_nxt];

   always_ff @(posedge SYS_CLK) begin
      if (accept) begin
         lb1[col_nxt] <= PIX_IN;
         lb2[col_nxt] <= lb1[col_nxt];
      end
   end

   always_comb begin
      for (int i = 0; i < 9; i++) begin
         win_nxt[i] = win[i];
      end
      if (accept) begin
         win_nxt[0] = win[1];
         win_nxt[1] = win[2];
         win_nxt[2] = line2;
         win_nxt[3] = win[4];
         win_nxt[4] = win[5];
         win_nxt[5] = line1;
         win_nxt[6] = win[7];
         win_nxt[7] = win[8];
         win_nxt[8] = PIX_IN;
      end
   end

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         for (int i = 0; i < 9; i++) begin
            win[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 9; i++) begin
            win[i] <= win_nxt[i];
         end
      end
   end

   // Select from the post-shift window so the new pixel is visible at once.
   always_comb begin
      sel_pix = '0;
      sel_bad = (CTRL_REGNUM_SEL > 4'd8);
      for (int i = 0; i < 9; i++) begin
         if (CTRL_REGNUM_SEL == 4'(i)) begin
            sel_pix = win_nxt[i];
         end
      end
   end

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         s1_pix <= '0;
         s1_vld <= 1'b0;
         s1_err <= 1'b0;
      end else begin
         s1_vld <= accept & rdy_nxt;
         s1_err <= PIX_VLD & sel_bad;
         if (accept & rdy_nxt) begin
            s1_pix <= sel_pix;
         end
      end
   end

`ifdef MUX19_OUT_REG_EN
   logic [DATA_W-1:0] s2_pix;
   logic              s2_vld;
   logic              s2_err;

   always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
         s2_pix <= '0;
         s2_vld <= 1'b0;
         s2_err <= 1'b0;
      end else begin
         s2_pix <= s1_pix;
         s2_vld <= s1_vld;
         s2_err <= s1_err;
      end
   end

   assign PIX_OUT     = s2_pix;
   assign PIX_OUT_VLD = s2_vld;
   assign SEL_ERR     = s2_err;
`else
   assign PIX_OUT     = s1_pix;
   assign PIX_OUT_VLD = s1_vld;
   assign SEL_ERR     = s1_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_1_9_win_sel.sv
`default_nettype none
// ============================================================================
// tb_mux_1_9_win_sel : vector table plus scoreboard bench for mux_1_9_win_sel.
// Revision 1.0 - initial release
// ============================================================================
module tb_mux_1_9_win_sel;

   localparam int DATA_W = 8;
   localparam int LINE_W = 8;
`ifdef MUX19_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic              SYS_CLK = 1'b0;
   logic              SYS_RST = 1'b0;
   logic              FRAME_SOF = 1'b0;
   logic              PIX_VLD = 1'b0;
   logic [DATA_W-1:0] PIX_IN = '0;
   logic [3:0]        CTRL_REGNUM_SEL = 4'd4;
   logic [DATA_W-1:0] PIX_OUT;
   logic              PIX_OUT_VLD;
   logic              WIN_RDY;
   logic              SEL_ERR;

   mux_1_9_win_sel #(.DATA_W(DATA_W), .LINE_W(LINE_W)) dut (
      .SYS_CLK         (SYS_CLK),
      .SYS_RST         (SYS_RST),
      .FRAME_SOF       (FRAME_SOF),
      .PIX_VLD         (PIX_VLD),
      .PIX_IN          (PIX_IN),
      .CTRL_REGNUM_SEL (CTRL_REGNUM_SEL),
      .PIX_OUT         (PIX_OUT),
      .PIX_OUT_VLD     (PIX_OUT_VLD),
      .WIN_RDY         (WIN_RDY),
      .SEL_ERR         (SEL_ERR)
   );

   always #5 SYS_CLK = ~SYS_CLK;

   typedef struct {
      logic       sof;
      int         gap;
      logic [7:0] pix;
      logic [3:0] sel;
      logic       exp_rdy;
      logic [7:0] exp_pix;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic [7:0] pix;
      logic       err;
      int         due;
   } sb_t;

   vec_t       vecs[$];
   sb_t        sb[$];
   sb_t        got;
   int         n_checks = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic       mon_en = 1'b0;
   logic [7:0] exp_hold = '0;
   logic [7:0] fpix [0:255];
   int         fn = 0;

   always @(posedge SYS_CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: frame kept as a flat raster; window tap k sits (2-k/3) lines
   // and (2-k%3) pixels behind the newest pixel.
   task automatic add_vec(input logic sof, input int gap, input logic [7:0] pix, input logic [3:0] sel);
      vec_t v;
      int   r;
      int   c;
      int   k;
      if (sof) fn = 0;
      fpix[fn]  = pix;
      r         = fn / LINE_W;
      c         = fn % LINE_W;
      v.sof     = sof;
      v.gap     = gap;
      v.pix     = pix;
      v.sel     = sel;
      v.exp_rdy = (r >= 2) && (c >= 2);
      v.exp_err = (sel > 4'd8);
      v.exp_pix = '0;
      if (v.exp_rdy && !v.exp_err) begin
         k         = int'(sel);
         v.exp_pix = fpix[fn - (2 - k / 3) * LINE_W - (2 - k % 3)];
      end
      fn++;
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v, input int idx);
      sb_t e;
      for (int g = 0; g < v.gap; g++) begin
         PIX_VLD   = 1'b0;
         FRAME_SOF = 1'b0;
         @(negedge SYS_CLK);
      end
      PIX_VLD         = 1'b1;
      FRAME_SOF       = v.sof;
      PIX_IN          = v.pix;
      CTRL_REGNUM_SEL = v.sel;
      if (v.exp_rdy) begin
         e.pix = v.exp_pix;
         e.err = v.exp_err;
         e.due = cyc + LAT;
         sb.push_back(e);
      end
      @(negedge SYS_CLK);
      PIX_VLD   = 1'b0;
      FRAME_SOF = 1'b0;
      check($sformatf("win_rdy[%0d]", idx), WIN_RDY, v.exp_rdy);
      if (v.sof && idx > 0) check($sformatf("restart_state[%0d]", idx), dut.state, 2'd1);
   endtask

   always @(negedge SYS_CLK) begin
      if (mon_en) begin
         if (PIX_OUT_VLD) begin
            if (sb.size() == 0) begin
               check("unexpected_out_vld", PIX_OUT_VLD, 1'b0);
            end else begin
               got = sb.pop_front();
               check("pix_out", PIX_OUT, got.pix);
               check("sel_err", SEL_ERR, got.err);
               check("latency", cyc, got.due);
               exp_hold = got.pix;
            end
         end else begin
            check("pix_hold", PIX_OUT, exp_hold);
            check("sel_err_idle", SEL_ERR, 1'b0);
         end
      end
   end

   initial begin
      // Frame A: ramp, centre tap.
      for (int n = 0; n < 24; n++) add_vec(n == 0, 0, 8'(n), 4'd4);
      // Frame B: ramp, corner / mixed / illegal taps on ready windows.
      for (int n = 0; n < 24; n++) begin
         logic [3:0] s;
         case (n)
            18:      s = 4'd0;
            19:      s = 4'd8;
            20:      s = 4'd12;
            21:      s = 4'd2;
            22:      s = 4'd6;
            23:      s = 4'd15;
            default: s = 4'd4;
         endcase
         add_vec(n == 0, 0, 8'(n), s);
      end
      // Frame C: ramp with random PIX_VLD gaps, running into the next line.
      for (int n = 0; n < 27; n++) add_vec(n == 0, (n == 0) ? 0 : int'($urandom_range(0, 2)), 8'(n), 4'd4);
      // Frame D: restart mid-line with a fresh pattern.
      for (int n = 0; n < 20; n++) add_vec(n == 0, 0, 8'((n * 7 + 100) & 255), 4'(n % 9));

      SYS_RST = 1'b1;
      repeat (2) @(negedge SYS_CLK);
      check("rst_pix_out", PIX_OUT, 8'd0);
      check("rst_out_vld", PIX_OUT_VLD, 1'b0);
      check("rst_win_rdy", WIN_RDY, 1'b0);
      check("rst_sel_err", SEL_ERR, 1'b0);
      check("rst_state", dut.state, 2'd0);
      SYS_RST = 1'b0;
      mon_en  = 1'b1;

      for (int i = 0; i < 5; i++) begin
         PIX_VLD = 1'b1;
         PIX_IN  = 8'(i + 200);
         @(negedge SYS_CLK);
         check("idle_ignore_state", dut.state, 2'd0);
         check("idle_ignore_rdy", WIN_RDY, 1'b0);
      end
      PIX_VLD = 1'b0;

      foreach (vecs[i]) apply(vecs[i], i);

      // Reset while an output is being presented.
      #2;
      SYS_RST = 1'b1;
      #1;
      check("midrun_rst_pix_out", PIX_OUT, 8'd0);
      check("midrun_rst_out_vld", PIX_OUT_VLD, 1'b0);
      check("midrun_rst_win_rdy", WIN_RDY, 1'b0);
      check("midrun_rst_sel_err", SEL_ERR, 1'b0);
      check("midrun_rst_state", dut.state, 2'd0);
      sb.delete();
      exp_hold = '0;
      @(negedge SYS_CLK);
      SYS_RST = 1'b0;

      for (int i = 0; i < 3; i++) begin
         PIX_VLD         = 1'b1;
         FRAME_SOF       = 1'b0;
         PIX_IN          = 8'(i + 50);
         CTRL_REGNUM_SEL = 4'd4;
         @(negedge SYS_CLK);
         check("post_rst_ignore_state", dut.state, 2'd0);
      end
      FRAME_SOF = 1'b1;
      @(negedge SYS_CLK);
      check("post_rst_sof_state", dut.state, 2'd1);
      PIX_VLD   = 1'b0;
      FRAME_SOF = 1'b0;

      repeat (LAT + 2) @(negedge SYS_CLK);
      check("scoreboard_empty", sb.size(), 0);
      mon_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mux_1_9_win_sel.md
MUX_1_9_WIN_SEL -- requirements
Module: mux_1_9_win_sel

Interface
REQ-001 Parameter DATA_W, default 8: pixel width in bits.
REQ-002 Parameter LINE_W, default 64: pixels per line; legal range 3..1024.
REQ-003 SYS_CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SYS_RST  input  1  asynchronous, active-high reset.
REQ-005 FRAME_SOF  input  1  start of frame; qualified by PIX_VLD; marks the first pixel of a frame.
REQ-006 PIX_VLD  input  1  PIX_IN valid this cycle.
REQ-007 PIX_IN  input  DATA_W  raster-order pixel.
REQ-008 CTRL_REGNUM_SEL  input  4  window register index from the upstream select-LUT controller; sampled with PIX_VLD.
REQ-009 PIX_OUT  output  DATA_W  selected window pixel.
REQ-010 PIX_OUT_VLD  output  1  PIX_OUT valid strobe.
REQ-011 WIN_RDY  output  1  level; high while the 3x3 window holds a complete neighbourhood.
REQ-012 SEL_ERR  output  1  one-cycle pulse flagging an illegal select index.

Function
REQ-013 Window is nine DATA_W registers w0..w8, row-major: w0..w2 oldest row, w6..w8 current row, w8 newest pixel.
REQ-014 Two line buffers of LINE_W entries each supply the pixels at the same column one line and two lines earlier.
REQ-015 On each accepted pixel: columns shift left, the new column loads {line2, line1, PIX_IN}, and the line buffers advance one entry.
REQ-016 Column counter runs 0..LINE_W-1 and wraps to 0; the row counter increments on each wrap and saturates at 2.
REQ-017 FSM states are IDLE, FILL and RUN.
REQ-018 IDLE -> FILL on PIX_VLD & FRAME_SOF.
REQ-019 FILL -> RUN when the row counter is 2 and the column counter is at least 2 after the update.
REQ-020 RUN holds until the next FRAME_SOF.
REQ-021 Any PIX_VLD & FRAME_SOF, in any state, clears both counters and enters FILL with that pixel as column 0.
REQ-022 In IDLE, PIX_VLD without FRAME_SOF is ignored.
REQ-023 WIN_RDY is high only in RUN while the column counter is at least 2, so windows that straddle a line wrap are masked.
REQ-024 Selection is PIX_OUT = w[CTRL_REGNUM_SEL] for indices 0..8, evaluated on the window after the accepted pixel's shift.
REQ-025 Indices 9..15 yield PIX_OUT = 0 and SEL_ERR = 1 for one cycle, qualified by PIX_VLD.
REQ-026 PIX_OUT_VLD pulses 1 cycle after an accepted pixel whose post-update WIN_RDY is high.
REQ-027 PIX_OUT holds its last value when PIX_OUT_VLD is low.
REQ-028 Gaps in PIX_VLD stall all state; there is no timeout.

Reset
REQ-029 SYS_RST asserted forces IDLE, clears the counters, window registers, PIX_OUT, PIX_OUT_VLD, WIN_RDY and SEL_ERR to 0, and discards any in-flight output immediately.
REQ-030 Line buffer contents are not reset; they are treated as don't-care until refilled after FRAME_SOF.
REQ-031 The first accepted input after SYS_RST deasserts is honoured on the next rising edge.

Configuration
REQ-032 Macro MUX19_OUT_REG_EN, when defined, adds one pipeline register after the selector; PIX_OUT, PIX_OUT_VLD and SEL_ERR latency becomes 2 cycles.
REQ-033 When MUX19_OUT_REG_EN is undefined, latency is 1 cycle as in REQ-026; all other behaviour is identical.

Verification
REQ-034 Scenario "centre pixel": LINE_W=8, FRAME_SOF then a ramp of values 0..23, CTRL_REGNUM_SEL=4. Required: the first PIX_OUT_VLD comes after pixel 18 (row 2, column 2) with PIX_OUT=9, then 10, 11, 12, 13, 14; no output for pixels 16 and 17.
REQ-035 Scenario "corners": same stimulus with select 0 at pixel 18. Required: PIX_OUT=0. With select 8 at pixel 19: PIX_OUT=19.
REQ-036 Scenario "illegal index": select 12 on a valid window. Required: PIX_OUT=0, SEL_ERR high exactly 1 cycle, PIX_OUT_VLD high.
REQ-037 Scenario "mid-frame restart": FRAME_SOF at row 1, column 5. Required: WIN_RDY drops next cycle, the state is FILL, and the first valid output reappears after 2*LINE_W+3 accepted pixels.
REQ-038 Scenario "reset and gaps": SYS_RST pulsed mid-RUN. Required: all outputs are 0 within the same cycle, the state is IDLE, and inputs without FRAME_SOF are ignored. Also: random PIX_VLD gaps produce the same output sequence as REQ-034.
REQ-039 Scenario "pipeline option": REQ-034 and REQ-036 rerun with MUX19_OUT_REG_EN defined. Required: the same values appear, each delayed by one extra cycle.
